pbch_llr_writer: RTL and testbench

Parametrised successor of the post-FFT LLR output stage. It accepts the serial descrambled PBCH LLR stream, packs `LLRS_PER_WORD` LLRs per memory word and writes the words round-robin across `NUM_BANKS` LLR RAMs. It counts a full codeword of `E_LLR` LLRs and then pulses `llr_done` to the polar-decoder side. It sits between `scrambler` and the LLR RAMs, replacing the fixed 2-bank, 4-LLR, 6-bit-address write path.

---
 rtl/pbch_llr_pkg.sv | 34 +++
 rtl/pbch_llr_writer_if.sv | 36 +++
 rtl/llr_lane_packer.sv | 56 +++++
 rtl/pbch_llr_writer.sv | 135 +++++++++++++
 tb/tb_pbch_llr_writer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/pbch_llr_pkg.sv
// -----------------------------------------------------------------------------
// pbch_llr_pkg
// Shared definitions for the PBCH LLR write path:
//   - E_LLR_DEF : default number of LLRs per PBCH codeword
//   - state_e   : writer control states
//   - llr_sat() : arithmetic shift plus symmetric clamp. It is used only when
//                 PBCH_LLR_SAT_EN is defined.
// -----------------------------------------------------------------------------
package pbch_llr_pkg;

    localparam int E_LLR_DEF = 864;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Shift x right arithmetically by 'shift'. Then clamp the result to
    // +/-(2^(llr_w-1)-1), so the most negative code of llr_w bits never
    // appears at the output.
    function automatic logic signed [31:0] llr_sat(input logic signed [31:0] x,
                                                   input int                 shift,
                                                   input int                 llr_w);
        logic signed [31:0] s;
        logic signed [31:0] lim;
        s   = x >>> shift;
        lim = (32'sd1 <<< (llr_w - 1)) - 32'sd1;
        if (s > lim)  return lim;
        if (s < -lim) return -lim;
        return s;
    endfunction

endpackage

// File: rtl/pbch_llr_writer_if.sv
// -----------------------------------------------------------------------------
// pbch_llr_writer_if
// Bundles the signals between scrambler, pbch_llr_writer and the LLR RAMs.
//   strt, in_vld, in_llr          : LLR stream and frame start (master drives)
//   mem_w_addr/data/en            : RAM word write port (slave drives)
//   busy, llr_done, stray_err     : status toward the polar decoder side
// The master modport is used by the stream source.
// The slave modport is used by pbch_llr_writer.
// -----------------------------------------------------------------------------
interface pbch_llr_writer_if #(
    parameter int IN_WIDTH      = 8,
    parameter int LLR_WIDTH     = 8,
    parameter int LLRS_PER_WORD = 4,
    parameter int NUM_BANKS     = 2,
    parameter int ADDR_WIDTH    = 7
);
    logic                               strt;
    logic                               in_vld;
    logic signed [IN_WIDTH-1:0]         in_llr;
    logic [ADDR_WIDTH-1:0]              mem_w_addr;
    logic [LLRS_PER_WORD*LLR_WIDTH-1:0] mem_w_data;
    logic [NUM_BANKS-1:0]               mem_w_en;
    logic                               busy;
    logic                               llr_done;
    logic                               stray_err;

    modport master (
        output strt, in_vld, in_llr,
        input  mem_w_addr, mem_w_data, mem_w_en, busy, llr_done, stray_err
    );

    modport slave (
        input  strt, in_vld, in_llr,
        output mem_w_addr, mem_w_data, mem_w_en, busy, llr_done, stray_err
    );
endinterface

// File: rtl/llr_lane_packer.sv
// -----------------------------------------------------------------------------
// llr_lane_packer
// Collects accepted LLRs into LLRS_PER_WORD lane registers. Lane 0 sits in the
// LSBs.
//   clk, rst   : clock and asynchronous active-low reset (lane counter only)
//   clr_i      : restarts packing at lane 0; the partial word is discarded
//   acc_i      : llr_i is accepted this cycle
//   llr_i      : reduced-width LLR
//   word_o     : lane contents, including the LLR accepted this cycle
//   word_cmp_o : this acceptance fills the last lane, so word_o is a full word
// -----------------------------------------------------------------------------
module llr_lane_packer #(
    parameter int LLR_WIDTH     = 8,
    parameter int LLRS_PER_WORD = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               clr_i,
    input  logic                               acc_i,
    input  logic [LLR_WIDTH-1:0]               llr_i,
    output logic [LLRS_PER_WORD*LLR_WIDTH-1:0] word_o,
    output logic                               word_cmp_o
);
    localparam int LANE_W = (LLRS_PER_WORD > 1) ? $clog2(LLRS_PER_WORD) : 1;

    logic [LANE_W-1:0]                         lane_q, lane_d;
    logic [LLRS_PER_WORD-1:0][LLR_WIDTH-1:0]   lanes_q, lanes_d;

    assign word_cmp_o = acc_i && (lane_q == LANE_W'(LLRS_PER_WORD - 1));
    // Expose the merged view so the parent can register the full word on the
    // same edge that accepts its last LLR.
    assign word_o     = lanes_d;

    always_comb begin
        lanes_d = lanes_q;
        if (acc_i) lanes_d[lane_q] = llr_i;
    end

    always_comb begin
        lane_d = lane_q;
        if (clr_i)           lane_d = '0;
        else if (word_cmp_o) lane_d = '0;
        else if (acc_i)      lane_d = lane_q + LANE_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) lane_q <= '0;
        else      lane_q <= lane_d;
    end

    // Lane storage is pure datapath; every lane is rewritten before a word
    // is issued, so it carries no reset.
    always_ff @(posedge clk) begin
        lanes_q <= lanes_d;
    end
endmodule

// File: rtl/pbch_llr_writer.sv
// -----------------------------------------------------------------------------
// pbch_llr_writer
// Packs the serial descrambled PBCH LLR stream into RAM words. It writes the
// words round-robin across NUM_BANKS LLR RAMs. After E_LLR LLRs it pulses
// llr_done.
//   clk, rst : clock (rising edge) and asynchronous active-low reset
//   bus      : pbch_llr_writer_if.slave
//              (strt, in_vld, in_llr in;
//               mem_w_addr, mem_w_data, mem_w_en, busy, llr_done, stray_err out)
// Configuration macro:
//   PBCH_LLR_SAT_EN defined   : shift right by IN_WIDTH-LLR_WIDTH, then clamp
//                               symmetrically.
//   PBCH_LLR_SAT_EN undefined : keep the top LLR_WIDTH bits and do not clamp.
// -----------------------------------------------------------------------------
module pbch_llr_writer
    import pbch_llr_pkg::*;
#(
    parameter int IN_WIDTH      = 8,
    parameter int LLR_WIDTH     = 8,
    parameter int LLRS_PER_WORD = 4,
    parameter int NUM_BANKS     = 2,
    parameter int E_LLR         = E_LLR_DEF,
    parameter int ADDR_WIDTH    = $clog2(E_LLR / (LLRS_PER_WORD * NUM_BANKS))
) (
    input  logic               clk,
    input  logic               rst,
    pbch_llr_writer_if.slave   bus
);
    localparam int DEPTH  = E_LLR / (LLRS_PER_WORD * NUM_BANKS);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam int WORD_W = LLRS_PER_WORD * LLR_WIDTH;

    state_e                  state_q, state_d;
    logic [BANK_W-1:0]       bank_q, bank_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   w_addr_q;
    logic [WORD_W-1:0]       w_data_q;
    logic [NUM_BANKS-1:0]    w_en_q, w_en_d;
    logic                    busy_q, done_q, stray_q, stray_d;
    logic                    acc, word_cmp, last_word;
    logic signed [LLR_WIDTH-1:0] llr_red;
    logic [WORD_W-1:0]       word;

    // A strt cycle always wins: an LLR that arrives with it is dropped.
    assign acc       = bus.in_vld && (state_q == RUN) && !bus.strt;
    assign last_word = (bank_q == BANK_W'(NUM_BANKS - 1)) &&
                       (addr_q == ADDR_WIDTH'(DEPTH - 1));

`ifdef PBCH_LLR_SAT_EN
    assign llr_red = LLR_WIDTH'(llr_sat(32'($signed(bus.in_llr)),
                                        IN_WIDTH - LLR_WIDTH, LLR_WIDTH));
`else
    assign llr_red = LLR_WIDTH'($signed(bus.in_llr) >>> (IN_WIDTH - LLR_WIDTH));
`endif

    llr_lane_packer #(
        .LLR_WIDTH     (LLR_WIDTH),
        .LLRS_PER_WORD (LLRS_PER_WORD)
    ) u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (bus.strt),
        .acc_i      (acc),
        .llr_i      (llr_red),
        .word_o     (word),
        .word_cmp_o (word_cmp)
    );

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        w_en_d  = '0;
        stray_d = stray_q;

        case (state_q)
            IDLE:    if (bus.strt) state_d = RUN;
            RUN:     if (bus.strt)                   state_d = RUN;
                     else if (word_cmp && last_word) state_d = DONE;
            DONE:    state_d = bus.strt ? RUN : IDLE;
            default: state_d = IDLE;
        endcase

        if (bus.strt) begin
            bank_d = '0;
            addr_d = '0;
        end else if (word_cmp) begin
            w_en_d[bank_q] = 1'b1;
            if (bank_q == BANK_W'(NUM_BANKS - 1)) begin
                bank_d = '0;
                addr_d = last_word ? '0 : addr_q + ADDR_WIDTH'(1);
            end else begin
                bank_d = bank_q + BANK_W'(1);
            end
        end

        // strt clears the sticky flag, unless the strt cycle itself carries
        // a stray LLR.
        if (bus.strt)                             stray_d = bus.in_vld;
        else if (bus.in_vld && state_q != RUN)    stray_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            bank_q   <= '0;
            addr_q   <= '0;
            w_addr_q <= '0;
            w_data_q <= '0;
            w_en_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            stray_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            w_en_q  <= w_en_d;
            busy_q  <= (state_d == RUN);
            done_q  <= word_cmp && last_word;
            stray_q <= stray_d;
            if (word_cmp) begin
                w_addr_q <= addr_q;
                w_data_q <= word;
            end
        end
    end

    assign bus.mem_w_addr = w_addr_q;
    assign bus.mem_w_data = w_data_q;
    assign bus.mem_w_en   = w_en_q;
    assign bus.busy       = busy_q;
    assign bus.llr_done   = done_q;
    assign bus.stray_err  = stray_q;
endmodule

// File: tb/tb_pbch_llr_writer.sv
// -----------------------------------------------------------------------------
// tb_pbch_llr_writer
// Scoreboard bench for pbch_llr_writer. Stimulus tasks push the expected RAM
// writes into a queue. A negedge monitor pops an entry and compares it against
// every write strobe or done pulse.
// A second instance, with IN_WIDTH=10, covers width reduction. Its expected
// values depend on PBCH_LLR_SAT_EN.
// -----------------------------------------------------------------------------
module tb_pbch_llr_writer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pbch_llr_writer_if #(.IN_WIDTH(8), .LLR_WIDTH(8), .LLRS_PER_WORD(4),
                         .NUM_BANKS(2), .ADDR_WIDTH(7)) bus ();
    pbch_llr_writer #(.IN_WIDTH(8), .LLR_WIDTH(8), .LLRS_PER_WORD(4),
                      .NUM_BANKS(2), .E_LLR(864), .ADDR_WIDTH(7))
        dut (.clk(clk), .rst(rst), .bus(bus));

    pbch_llr_writer_if #(.IN_WIDTH(10), .LLR_WIDTH(8), .LLRS_PER_WORD(4),
                         .NUM_BANKS(2), .ADDR_WIDTH(1)) wbus ();
    pbch_llr_writer #(.IN_WIDTH(10), .LLR_WIDTH(8), .LLRS_PER_WORD(4),
                      .NUM_BANKS(2), .E_LLR(16), .ADDR_WIDTH(1))
        wdut (.clk(clk), .rst(rst), .bus(wbus));

    typedef struct packed {
        logic [1:0]  en;
        logic [6:0]  addr;
        logic [31:0] data;
        logic        done;
        logic        busy;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_act, mon_exp;
    int  vectors     = 0;
    int  miscompares = 0;
    int  done_cnt    = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endfunction

    // Three distinct LLR sequences, so one frame is never confused with another.
    function automatic logic [7:0] llr_val(input int id, input int i);
        case (id)
            0:       return 8'(i % 256);
            1:       return 8'((i + 100) % 256);
            default: return 8'(255 - (i % 256));
        endcase
    endfunction

    function automatic void push_word(input int id, input int k, input bit done);
        wr_t e;
        e.en   = (k % 2 == 0) ? 2'b01 : 2'b10;
        e.addr = 7'(k / 2);
        e.data = {llr_val(id, 4*k+3), llr_val(id, 4*k+2),
                  llr_val(id, 4*k+1), llr_val(id, 4*k)};
        e.done = done;
        e.busy = !done;
        exp_q.push_back(e);
    endfunction

    // Monitor: compare each strobe or done pulse against the scoreboard.
    always @(negedge clk) begin
        if (bus.mem_w_en != 2'b00 || bus.llr_done) begin
            mon_act = {bus.mem_w_en, bus.mem_w_addr, bus.mem_w_data,
                       bus.llr_done, bus.busy};
            if (exp_q.size() == 0) begin
                check("unexpected_write", 64'(mon_act), 64'(0));
            end else begin
                mon_exp = exp_q.pop_front();
                check("write", 64'(mon_act), 64'(mon_exp));
            end
        end
        if (bus.llr_done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_strt(input bit vld);
        bus.strt   = 1'b1;
        bus.in_vld = vld;
        tick();
        bus.strt   = 1'b0;
        bus.in_vld = 1'b0;
    endtask

    task automatic send(input logic [7:0] v);
        bus.in_vld = 1'b1;
        bus.in_llr = v;
        tick();
        bus.in_vld = 1'b0;
    endtask

    task automatic send_w(input logic [9:0] v);
        wbus.in_vld = 1'b1;
        wbus.in_llr = v;
        tick();
        wbus.in_vld = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int c = 0; c < 64 && exp_q.size() != 0; c++) tick();
        check(name, 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    task automatic run_frame(input int id, input bit gaps);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 216; k++) push_word(id, k, k == 215);
        do_strt(1'b0);
        check("busy_after_strt", 64'(bus.busy), 64'(1));
        for (int i = 0; i < 864; i++) begin
            if (gaps)
                for (int g = 0; g < 8 && $urandom_range(1, 0) == 1; g++) tick();
            send(llr_val(id, i));
        end
        drain("frame_drain");
        tick();
        check("done_once", 64'(done_cnt - d0), 64'(1));
        check("busy_idle", 64'(bus.busy), 64'(0));
    endtask

    initial begin
        logic [31:0] w0, w1;
`ifdef PBCH_LLR_SAT_EN
        w0 = {8'h01, 8'h00, 8'h7F, 8'h81};
        w1 = {8'h02, 8'hFF, 8'h81, 8'h7F};
`else
        w0 = {8'h01, 8'h00, 8'h7F, 8'h80};
        w1 = {8'h02, 8'hFF, 8'h80, 8'h7F};
`endif
        bus.strt  = 1'b0; bus.in_vld  = 1'b0; bus.in_llr  = '0;
        wbus.strt = 1'b0; wbus.in_vld = 1'b0; wbus.in_llr = '0;

        // Reset state
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("reset_outputs", 64'({bus.mem_w_addr, bus.mem_w_data, bus.mem_w_en,
                                    bus.busy, bus.llr_done, bus.stray_err}), 64'(0));
        check("reset_outputs_w", 64'({wbus.mem_w_addr, wbus.mem_w_data, wbus.mem_w_en,
                                      wbus.busy, wbus.llr_done, wbus.stray_err}), 64'(0));

        // Gapless frame of 0..863, then the same frame with random gaps
        run_frame(0, 1'b0);
        check("stray_clean", 64'(bus.stray_err), 64'(0));
        run_frame(0, 1'b1);

        // Abort after 10 LLRs: two words land, then the new frame restarts at bank 0/addr 0
        push_word(0, 0, 1'b0);
        push_word(0, 1, 1'b0);
        do_strt(1'b0);
        for (int i = 0; i < 10; i++) send(llr_val(0, i));
        run_frame(1, 1'b0);

        // Stray LLRs in IDLE and in the strt cycle
        bus.in_vld = 1'b1;
        bus.in_llr = 8'h55;
        tick();
        bus.in_vld = 1'b0;
        check("stray_idle", 64'(bus.stray_err), 64'(1));
        do_strt(1'b0);
        check("stray_clr", 64'(bus.stray_err), 64'(0));
        do_strt(1'b1);
        check("stray_strt", 64'(bus.stray_err), 64'(1));
        run_frame(2, 1'b1);
        check("stray_after_frame", 64'(bus.stray_err), 64'(0));

        // Width reduction: IN_WIDTH=10 -> LLR_WIDTH=8
        wbus.strt = 1'b1;
        tick();
        wbus.strt = 1'b0;
        send_w(10'h200); send_w(10'h1FF); send_w(10'h000); send_w(10'h004);
        check("wid_en0", 64'(wbus.mem_w_en), 64'(2'b01));
        check("wid_data0", 64'(wbus.mem_w_data), 64'(w0));
        send_w(10'h1FF); send_w(10'h200); send_w(10'h3FC); send_w(10'h008);
        check("wid_en1", 64'(wbus.mem_w_en), 64'(2'b10));
        check("wid_data1", 64'(wbus.mem_w_data), 64'(w1));

        // Reset after 400 LLRs, then a full frame from address 0
        for (int k = 0; k < 100; k++) push_word(0, k, 1'b0);
        do_strt(1'b0);
        for (int i = 0; i < 400; i++) send(llr_val(0, i));
        drain("pre_reset_drain");
        rst = 1'b0;
        #1;
        check("midframe_reset", 64'({bus.mem_w_addr, bus.mem_w_data, bus.mem_w_en,
                                     bus.busy, bus.llr_done, bus.stray_err}), 64'(0));
        tick();
        rst = 1'b1;
        tick();
        run_frame(2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, limit 2000000 time units");
        $fatal(1, "watchdog");
    end
endmodule
